alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter MULDIV_WAIT, default 32, extra EXEC-hold cycles granted to mul (01111) and div (10000) before result capture; legal 1..255.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  requester has an operation pending.
REQ-005 req_ready  output  1  sequencer accepts a request this cycle.
REQ-006 req_op  input  5  ALU opcode.
REQ-007 req_a, req_b  input  32 each  operand A (Y side) and operand B (bus side).
REQ-008 alu_y, alu_bus  output  32 each  registered operands driven to the ALU.
REQ-009 alu_ctrl  output  5  registered opcode driven to the ALU.
REQ-010 alu_z  input  64  ALU result.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  consumer takes the result.
REQ-013 rsp_lo, rsp_hi  output  32 each  captured alu_z[31:0] and alu_z[63:32].
REQ-014 rsp_err  output  1  result invalid (illegal opcode; divide-by-zero when enabled).
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 States: IDLE, EXEC, WAIT, DONE; exactly one active.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-018 On accept, alu_y<=req_a, alu_bus<=req_b, alu_ctrl<=req_op; state IDLE->EXEC.
REQ-019 Legal opcodes: 00011-01011, 01111, 10000, 10001, 10010; any other opcode SHALL go EXEC->DONE with rsp_err=1, rsp_lo=rsp_hi=0.
REQ-020 Simple legal op: EXEC->DONE after one cycle, capturing alu_z at that edge; rsp_valid rises exactly 2 edges after accept.
REQ-021 mul/div: EXEC->WAIT; WAIT counter loads MULDIV_WAIT, decrements per cycle, captures alu_z and enters DONE when it reaches 0; rsp_valid rises 2+MULDIV_WAIT edges after accept.
REQ-022 alu_y, alu_bus, alu_ctrl SHALL remain stable from accept until DONE is left.
REQ-023 DONE holds rsp_valid, rsp_lo, rsp_hi, rsp_err stable until rsp_ready=1; on that edge state->IDLE, rsp_valid->0.
REQ-024 rsp_ready while rsp_valid=0 SHALL be ignored; req_valid outside IDLE SHALL be ignored (no queuing).
REQ-025 On leaving DONE, alu_ctrl SHALL return to 00000; alu_y/alu_bus retain last value.
REQ-026 Minimum request-to-request spacing: 3 cycles for back-to-back simple ops with rsp_ready tied high.

Reset
REQ-027 clear=0 SHALL immediately force IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_err=0, all data outputs and alu_ctrl to 0, wait counter to 0.
REQ-028 Reset during EXEC/WAIT/DONE SHALL discard the in-flight operation with no response.

Configuration
REQ-029 Macro ALU_SEQ_DIVZERO_CHECK_EN: when defined, div with req_b==0 SHALL skip WAIT, go EXEC->DONE with rsp_err=1, rsp_lo=rsp_hi=0; when undefined, div by zero runs normally and rsp_err reflects only illegal opcodes.

Structure
REQ-030 Package alu_seq_pkg SHALL hold the opcode constants (ADD..NOT), state enumeration, and the legal-opcode/is-muldiv helper functions, shared with the ALU bench.
REQ-031 WAIT counter SHALL be a sub-module alu_seq_wait_cnt (load, decrement, zero flag, width 8).

Verification
REQ-032 Reset then add A=5,B=7: rsp_valid at accept+2, rsp_lo=12, rsp_hi=0, rsp_err=0.
REQ-033 mul A=0x10000,B=0x10000, MULDIV_WAIT=32: rsp_valid at accept+34, rsp_hi=1, rsp_lo=0; alu_ctrl stable =01111 throughout.
REQ-034 Opcode 01100: rsp_err=1, rsp_lo=rsp_hi=0, rsp_valid at accept+2.
REQ-035 rsp_ready held 0 for 10 cycles after result: outputs stable, req_ready=0, second req_valid ignored; then rsp_ready=1 -> IDLE next edge.
REQ-036 clear pulsed low mid-WAIT of div: all outputs zero immediately, no response issued, next add completes normally.
REQ-037 With ALU_SEQ_DIVZERO_CHECK_EN, div A=9,B=0: rsp_err=1 at accept+2; without it, response at accept+2+MULDIV_WAIT, rsp_err=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode classification
// helpers for the ALU operation sequencer and its ALU bench.
package alu_seq_pkg;

   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100;
   localparam logic [4:0] OP_AND = 5'b00101;
   localparam logic [4:0] OP_OR  = 5'b00110;
   localparam logic [4:0] OP_XOR = 5'b00111;
   localparam logic [4:0] OP_SLL = 5'b01000;
   localparam logic [4:0] OP_SRL = 5'b01001;
   localparam logic [4:0] OP_SRA = 5'b01010;
   localparam logic [4:0] OP_SLT = 5'b01011;
   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;
   localparam logic [4:0] OP_NEG = 5'b10001;
   localparam logic [4:0] OP_NOT = 5'b10010;

   localparam int WAIT_CNT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      WAIT,
      DONE
   } seqState_t;

   function automatic logic isLegalOp(input logic [4:0] op);
      return ((op >= OP_ADD) && (op <= OP_SLT)) ||
             (op == OP_MUL) || (op == OP_DIV) ||
             (op == OP_NEG) || (op == OP_NOT);
   endfunction

   function automatic logic isMulDiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_seq_wait_cnt.sv
// Loadable down-counter that holds the sequencer in WAIT while a multi-cycle
// mul/div settles; saturates at zero.
module alu_seq_wait_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] loadValue,
   input  logic             decrement,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             expiring
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         count <= '0;
      end else if (load) begin
         count <= loadValue;
      end else if (decrement && !zero) begin
         count <= count - 1'b1;
      end
   end

   assign zero     = (count == '0);
   assign expiring = (count == WIDTH'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Single-request ALU operation sequencer: latches operands, waits out mul/div
// latency and holds the result until consumed. Optional macro
// ALU_SEQ_DIVZERO_CHECK_EN flags div-by-zero as an error without waiting.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int MULDIV_WAIT = 32
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] alu_y,
   output logic [31:0] alu_bus,
   output logic [4:0]  alu_ctrl,
   input  logic [63:0] alu_z,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_lo,
   output logic [31:0] rsp_hi,
   output logic        rsp_err,
   output logic        busy
);

   seqState_t state, stateNext;

   logic accept, capture, captureErr, retire;
   logic cntLoad, cntDec, cntZero, cntExpiring, divZero;
   logic [WAIT_CNT_WIDTH-1:0] cntValue;

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
   assign divZero = (alu_ctrl == OP_DIV) && (alu_bus == '0);
`else
   assign divZero = 1'b0;
`endif

   alu_seq_wait_cnt #(.WIDTH(WAIT_CNT_WIDTH)) waitCnt (
      .clock     (clock),
      .clear     (clear),
      .load      (cntLoad),
      .loadValue (WAIT_CNT_WIDTH'(MULDIV_WAIT)),
      .decrement (cntDec),
      .count     (cntValue),
      .zero      (cntZero),
      .expiring  (cntExpiring)
   );

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state <= IDLE;
      else        state <= stateNext;
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave it unassigned and infer a latch.
   always_comb begin
      stateNext  = state;
      accept     = 1'b0;
      capture    = 1'b0;
      captureErr = 1'b0;
      retire     = 1'b0;
      cntLoad    = 1'b0;
      cntDec     = 1'b0;
      unique case (state)
         IDLE: if (req_valid) begin
            accept    = 1'b1;
            stateNext = EXEC;
         end
         EXEC: if (!isLegalOp(alu_ctrl) || divZero) begin
            captureErr = 1'b1;
            stateNext  = DONE;
         end else if (isMulDiv(alu_ctrl)) begin
            cntLoad   = 1'b1;
            stateNext = WAIT;
         end else begin
            capture   = 1'b1;
            stateNext = DONE;
         end
         WAIT: begin
            cntDec = 1'b1;
            // A zero count in WAIT is only reachable on a corrupted load; exit anyway.
            if (cntExpiring || cntZero) begin
               capture   = 1'b1;
               stateNext = DONE;
            end
         end
         DONE: if (rsp_ready) begin
            retire    = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         alu_y    <= '0;
         alu_bus  <= '0;
         alu_ctrl <= '0;
         rsp_lo   <= '0;
         rsp_hi   <= '0;
         rsp_err  <= 1'b0;
      end else begin
         if (accept) begin
            alu_y    <= req_a;
            alu_bus  <= req_b;
            alu_ctrl <= req_op;
         end
         if (retire) alu_ctrl <= '0;
         if (capture) begin
            rsp_lo  <= alu_z[31:0];
            rsp_hi  <= alu_z[63:32];
            rsp_err <= 1'b0;
         end
         if (captureErr) begin
            rsp_lo  <= '0;
            rsp_hi  <= '0;
            rsp_err <= 1'b1;
         end
      end
   end

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign rsp_valid = (state == DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed requests push expected
// responses; a negedge monitor pops and compares each response it sees.
module tb_alu_op_sequencer;
   import alu_seq_pkg::*;

   localparam int W = 32;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_op = '0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [31:0] alu_y, alu_bus;
   logic [4:0]  alu_ctrl;
   logic [63:0] alu_z;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_lo, rsp_hi;
   logic        rsp_err;
   logic        busy;

   alu_op_sequencer #(.MULDIV_WAIT(W)) dut (
      .clock     (clock),
      .clear     (clear),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .alu_y     (alu_y),
      .alu_bus   (alu_bus),
      .alu_ctrl  (alu_ctrl),
      .alu_z     (alu_z),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_lo    (rsp_lo),
      .rsp_hi    (rsp_hi),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   // Stand-in ALU; illegal opcodes produce a nonzero pattern that must not leak out.
   always_comb begin
      case (alu_ctrl)
         OP_ADD:  alu_z = {32'h0, alu_y + alu_bus};
         OP_SUB:  alu_z = {32'h0, alu_y - alu_bus};
         OP_MUL:  alu_z = {32'h0, alu_y} * {32'h0, alu_bus};
         OP_DIV:  alu_z = (alu_bus == 32'h0) ? {alu_y, 32'hFFFF_FFFF}
                                             : {alu_y % alu_bus, alu_y / alu_bus};
         default: alu_z = {alu_y ^ 32'hA5A5_A5A5, alu_bus ^ 32'h5A5A_5A5A};
      endcase
   end

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        err;
      int          due;
   } exp_t;

   exp_t sbQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   always @(posedge clock) cycle <= cycle + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Monitor: compare on the rising edge of rsp_valid, then check it holds.
   logic        prevValid = 1'b0;
   logic [31:0] heldLo, heldHi;
   logic        heldErr;
   exp_t        cur;

   always @(negedge clock) begin
      if (rsp_valid && !prevValid) begin
         if (sbQ.size() == 0) begin
            check("unexpected_rsp", 64'd1, 64'd0);
         end else begin
            cur = sbQ.pop_front();
            check("rsp_lo", rsp_lo, cur.lo);
            check("rsp_hi", rsp_hi, cur.hi);
            check("rsp_err", rsp_err, cur.err);
            check("rsp_latency", cycle, cur.due);
         end
         heldLo  = rsp_lo;
         heldHi  = rsp_hi;
         heldErr = rsp_err;
      end else if (rsp_valid) begin
         check("rsp_hold_lo", rsp_lo, heldLo);
         check("rsp_hold_hi", rsp_hi, heldHi);
         check("rsp_hold_err", rsp_err, heldErr);
      end
      prevValid = rsp_valid;
   end

   // Presents a request from a negedge and returns the cycle it was accepted in.
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eLo, input logic [31:0] eHi, input logic eErr,
                        input int eLat, input bit push, output int accCyc);
      exp_t e;
      int   n = 0;
      @(negedge clock);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      while (!req_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      accCyc = cycle;
      if (!req_ready) begin
         check("req_accept_timeout", 64'd0, 64'd1);
         req_valid = 1'b0;
         return;
      end
      if (push) begin
         e.lo  = eLo;
         e.hi  = eHi;
         e.err = eErr;
         e.due = accCyc + eLat;
         sbQ.push_back(e);
      end
      @(posedge clock);
      #1 req_valid = 1'b0;
   endtask

   task automatic waitIdle(input logic [4:0] ctrlExp, input bit chk);
      int n = 0;
      while (busy && n < 300) begin
         if (chk) check("alu_ctrl_stable", alu_ctrl, ctrlExp);
         @(negedge clock);
         n++;
      end
      check("idle_timeout", busy, 64'd0);
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_req_ready"}, req_ready, 64'd1);
      check({tag, "_busy"}, busy, 64'd0);
      check({tag, "_rsp_valid"}, rsp_valid, 64'd0);
      check({tag, "_rsp_err"}, rsp_err, 64'd0);
      check({tag, "_rsp_lo"}, rsp_lo, 64'd0);
      check({tag, "_rsp_hi"}, rsp_hi, 64'd0);
      check({tag, "_alu_y"}, alu_y, 64'd0);
      check({tag, "_alu_bus"}, alu_bus, 64'd0);
      check({tag, "_alu_ctrl"}, alu_ctrl, 64'd0);
   endtask

   initial begin
      int c1, c2;
      int n;

      #12 checkAllZero("reset");
      @(negedge clock);
      clear = 1'b1;

      // add 5+7
      issue(OP_ADD, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 2, 1'b1, c1);
      waitIdle(OP_ADD, 1'b1);
      check("ctrl_cleared_after_add", alu_ctrl, 64'd0);

      // mul 0x10000*0x10000 = 2^32
      issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 1'b0, 2 + W, 1'b1, c1);
      check("mul_alu_y", alu_y, 64'h0001_0000);
      waitIdle(OP_MUL, 1'b1);
      check("ctrl_cleared_after_mul", alu_ctrl, 64'd0);
      check("alu_y_retained", alu_y, 64'h0001_0000);
      check("alu_bus_retained", alu_bus, 64'h0001_0000);

      // illegal opcode
      issue(5'b01100, 32'd3, 32'd4, 32'd0, 32'd0, 1'b1, 2, 1'b1, c1);
      waitIdle(5'b01100, 1'b1);

      // sub 10-3
      issue(OP_SUB, 32'd10, 32'd3, 32'd7, 32'd0, 1'b0, 2, 1'b1, c1);
      waitIdle(OP_SUB, 1'b1);

      // back-to-back simple ops: accepted 3 cycles apart
      issue(OP_ADD, 32'd1, 32'd1, 32'd2, 32'd0, 1'b0, 2, 1'b1, c1);
      issue(OP_ADD, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 2, 1'b1, c2);
      check("b2b_spacing", c2 - c1, 64'd3);
      waitIdle(OP_ADD, 1'b1);

      // held response with a stray request while in DONE
      rsp_ready = 1'b0;
      issue(OP_ADD, 32'd20, 32'd22, 32'd42, 32'd0, 1'b0, 2, 1'b1, c1);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("hold_valid_seen", rsp_valid, 64'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (i == 3) begin
            req_valid = 1'b1;
            req_op    = OP_SUB;
            req_a     = 32'd99;
            req_b     = 32'd1;
         end
         if (i == 7) req_valid = 1'b0;
         check("hold_req_ready", req_ready, 64'd0);
         check("hold_rsp_valid", rsp_valid, 64'd1);
         check("hold_alu_y", alu_y, 64'd20);
         check("hold_alu_ctrl", alu_ctrl, OP_ADD);
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      check("release_rsp_valid", rsp_valid, 64'd0);
      check("release_busy", busy, 64'd0);
      check("release_alu_ctrl", alu_ctrl, 64'd0);
      check("release_alu_y", alu_y, 64'd20);

      // div 100/7
      issue(OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 2 + W, 1'b1, c1);
      waitIdle(OP_DIV, 1'b1);

      // reset mid-WAIT of a div: no response may follow
      issue(OP_DIV, 32'd100, 32'd3, 32'd0, 32'd0, 1'b0, 0, 1'b0, c1);
      repeat (10) @(negedge clock);
      check("div_in_wait_busy", busy, 64'd1);
      clear = 1'b0;
      #1 checkAllZero("midwait_reset");
      @(negedge clock);
      clear = 1'b1;
      repeat (40) @(negedge clock);
      check("no_rsp_after_reset", rsp_valid, 64'd0);

      issue(OP_ADD, 32'd1, 32'd2, 32'd3, 32'd0, 1'b0, 2, 1'b1, c1);
      waitIdle(OP_ADD, 1'b1);

      // div by zero
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
      issue(OP_DIV, 32'd9, 32'd0, 32'd0, 32'd0, 1'b1, 2, 1'b1, c1);
`else
      issue(OP_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b0, 2 + W, 1'b1, c1);
`endif
      waitIdle(OP_DIV, 1'b1);

      n = 0;
      while (sbQ.size() != 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("scoreboard_drained", sbQ.size(), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
